// File: rtl/mlp_seq_pkg.sv
// Shared types and constants for the MLP job sequencer.
package mlp_seq_pkg;

    // Sequencer states; StIdle must stay at zero so the debug port reads 0 after reset.
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StWfRst   = 3'd1,
        StLoadW   = 3'd2,
        StLoadAct = 3'd3,
        StArm     = 3'd4,
        StRun     = 3'd5,
        StResp    = 3'd6
    } seq_state_t;

    // Result status codes.
    localparam logic [1:0] SEQ_OK      = 2'd0;
    localparam logic [1:0] SEQ_TIMEOUT = 2'd1;
    localparam logic [1:0] SEQ_BAD_ARG = 2'd2;

endpackage

// File: rtl/weight_stream_reader.sv
// Streams a job's weight bytes from the weight memory into the two column FIFOs.
// Reads issue one per cycle; each byte is pushed the cycle after its read, WBYTES
// bytes to column 0 followed by WBYTES bytes to column 1, repeating per layer.
module weight_stream_reader
    import mlp_seq_pkg::*;
#(
    parameter int unsigned WBYTES = 4,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = $clog2(7 * 2 * WBYTES + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [CNT_W-1:0]  total_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] addr_o,
    input  logic [7:0]        rd_data_i,
    output logic              push_col0_o,
    output logic              push_col1_o,
    output logic [7:0]        data_o,
    output logic              done_o
);

    localparam int unsigned PosW = $clog2(2 * WBYTES);

    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [PosW-1:0]   pos_q, pos_d;
    logic              push0_q, push0_d;
    logic              push1_q, push1_d;
    logic              last_q, last_d;
    logic              last_read;

    assign last_read = (idx_q == total_i - 1'b1);

    // Read address/byte counters and the column select for the byte being read.
    always_comb begin
        rd_en_d = rd_en_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        if (start_i) begin
            rd_en_d = 1'b1;
            addr_d  = base_i;
            idx_d   = '0;
            pos_d   = '0;
        end else if (rd_en_q) begin
            addr_d = addr_q + 1'b1;
            idx_d  = idx_q + 1'b1;
            pos_d  = (pos_q == PosW'(2 * WBYTES - 1)) ? '0 : pos_q + 1'b1;
            if (last_read) begin
                rd_en_d = 1'b0;
            end
        end
        push0_d = rd_en_q && (pos_q < PosW'(WBYTES));
        push1_d = rd_en_q && !(pos_q < PosW'(WBYTES));
        last_d  = rd_en_q && last_read;
    end

    // Counter and read-to-push pipeline registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            idx_q   <= '0;
            pos_q   <= '0;
            push0_q <= 1'b0;
            push1_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            push0_q <= push0_d;
            push1_q <= push1_d;
            last_q  <= last_d;
        end
    end

    assign rd_en_o     = rd_en_q;
    assign addr_o      = addr_q;
    assign push_col0_o = push0_q;
    assign push_col1_o = push1_q;
    // Memory data arrives the cycle after the read; gate it so idle cycles show zero.
    assign data_o      = (push0_q || push1_q) ? rd_data_i : 8'h00;
    assign done_o      = last_q;

endmodule

// File: rtl/mlp_sequencer.sv
// Autonomous MLP job sequencer: loads weights and activations, starts the MLP,
// counts layers and returns the final accumulators with a status code.
module mlp_sequencer
    import mlp_seq_pkg::*;
#(
    parameter int unsigned WBYTES         = 4,
    parameter int unsigned ACT_WORDS      = 2,
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [ADDR_W-1:0]       job_wbase,
    input  logic [16*ACT_WORDS-1:0] job_act,
    input  logic [2:0]              job_num_layers,
    output logic                    wmem_rd_en,
    output logic [ADDR_W-1:0]       wmem_addr,
    input  logic [7:0]              wmem_rd_data,
    output logic                    wf_reset,
    output logic                    wf_push_col0,
    output logic                    wf_push_col1,
    output logic [7:0]              wf_data_in,
    output logic                    init_act_valid,
    output logic [15:0]             init_act_data,
    output logic                    start_mlp,
    output logic                    weights_ready,
    input  logic                    mlp_layer_complete,
    input  logic                    mlp_acc_valid,
    input  logic signed [31:0]      mlp_acc0,
    input  logic signed [31:0]      mlp_acc1,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [31:0]      res_acc0,
    output logic signed [31:0]      res_acc1,
    output logic [1:0]              res_status,
    output logic                    busy,
    output logic [2:0]              seq_state_dbg
);

    localparam int unsigned CntW  = $clog2(7 * 2 * WBYTES + 1);
    localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned AidxW = $clog2(ACT_WORDS + 1);

    seq_state_t              state_q, state_d;
    logic [ADDR_W-1:0]       wbase_q, wbase_d;
    logic [16*ACT_WORDS-1:0] act_q, act_d;
    logic [2:0]              layers_q, layers_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [TmoW-1:0]         tmo_q, tmo_d;
    logic signed [31:0]      acc0_q, acc0_d;
    logic signed [31:0]      acc1_q, acc1_d;
    logic [1:0]              status_q, status_d;
    logic [AidxW-1:0]        act_idx_q, act_idx_d;

    logic                    wf_reset_q, start_mlp_q, weights_ready_q;
    logic                    res_valid_q, busy_q, init_act_valid_q;
    logic [15:0]             init_act_data_q, act_word;

    logic                    ws_start, ws_done;
    logic [CntW-1:0]         ws_total;

    assign ws_total = CntW'(layers_q) * CntW'(2 * WBYTES);
    assign act_word = 16'(act_q >> {act_idx_q, 4'b0000});

    weight_stream_reader #(
        .WBYTES (WBYTES),
        .ADDR_W (ADDR_W),
        .CNT_W  (CntW)
    ) u_reader (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (ws_start),
        .base_i      (wbase_q),
        .total_i     (ws_total),
        .rd_en_o     (wmem_rd_en),
        .addr_o      (wmem_addr),
        .rd_data_i   (wmem_rd_data),
        .push_col0_o (wf_push_col0),
        .push_col1_o (wf_push_col1),
        .data_o      (wf_data_in),
        .done_o      (ws_done)
    );

    // Next-state logic: job latch, layer/timeout counting and result capture.
    always_comb begin
        state_d  = state_q;
        wbase_d  = wbase_q;
        act_d    = act_q;
        layers_d = layers_q;
        cnt_d    = cnt_q;
        acc0_d   = acc0_q;
        acc1_d   = acc1_q;
        status_d = status_q;
        ws_start = 1'b0;
        // Counts cycles spent in RUN; zero on entry, saturating.
        tmo_d    = '0;
        if (state_q == StRun) begin
            tmo_d = (tmo_q == TmoW'(TIMEOUT_CYCLES)) ? tmo_q : tmo_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (job_valid) begin
                    wbase_d  = job_wbase;
                    act_d    = job_act;
                    layers_d = job_num_layers;
                    cnt_d    = '0;
                    acc0_d   = '0;
                    acc1_d   = '0;
                    if (job_num_layers == 3'd0) begin
                        status_d = SEQ_BAD_ARG;
                        state_d  = StResp;
                    end else begin
                        status_d = SEQ_OK;
                        state_d  = StWfRst;
                    end
                end
            end
            StWfRst: begin
                ws_start = 1'b1;
                state_d  = StLoadW;
            end
            StLoadW: begin
                if (ws_done) begin
                    state_d = StLoadAct;
                end
            end
            StLoadAct: begin
                if (act_idx_q == AidxW'(ACT_WORDS)) begin
                    state_d = StArm;
                end
            end
            StArm: begin
                state_d = StRun;
            end
            StRun: begin
                if (mlp_acc_valid) begin
                    acc0_d = mlp_acc0;
                    acc1_d = mlp_acc1;
                end
                cnt_d = cnt_q + {2'b00, mlp_layer_complete};
                // Final layer beats a timeout landing in the same cycle.
                if (cnt_d == layers_q) begin
                    status_d = SEQ_OK;
                    state_d  = StResp;
                end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                    status_d = SEQ_TIMEOUT;
                    state_d  = StResp;
                end
            end
            StResp: begin
                if (res_ready) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // act_idx_q is the next word to emit; it reaches ACT_WORDS on the last word.
        act_idx_d = (state_d == StLoadAct) ? act_idx_q + 1'b1 : '0;
    end

    // State, job fields and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StIdle;
            wbase_q          <= '0;
            act_q            <= '0;
            layers_q         <= '0;
            cnt_q            <= '0;
            tmo_q            <= '0;
            acc0_q           <= '0;
            acc1_q           <= '0;
            status_q         <= SEQ_OK;
            act_idx_q        <= '0;
            wf_reset_q       <= 1'b0;
            start_mlp_q      <= 1'b0;
            weights_ready_q  <= 1'b0;
            res_valid_q      <= 1'b0;
            busy_q           <= 1'b0;
            init_act_valid_q <= 1'b0;
            init_act_data_q  <= '0;
        end else begin
            state_q          <= state_d;
            wbase_q          <= wbase_d;
            act_q            <= act_d;
            layers_q         <= layers_d;
            cnt_q            <= cnt_d;
            tmo_q            <= tmo_d;
            acc0_q           <= acc0_d;
            acc1_q           <= acc1_d;
            status_q         <= status_d;
            act_idx_q        <= act_idx_d;
            wf_reset_q       <= (state_d == StWfRst);
            start_mlp_q      <= (state_d == StArm);
            res_valid_q      <= (state_d == StResp);
            busy_q           <= (state_d != StIdle);
            init_act_valid_q <= (state_d == StLoadAct);
            init_act_data_q  <= (state_d == StLoadAct) ? act_word : 16'h0000;
            // Held from ARM until the result handshake; never set on a BAD_ARG job.
            if (state_d == StArm) begin
                weights_ready_q <= 1'b1;
            end else if (state_d == StIdle) begin
                weights_ready_q <= 1'b0;
            end
        end
    end

    assign job_ready      = (state_q == StIdle);
    assign wf_reset       = wf_reset_q;
    assign start_mlp      = start_mlp_q;
    assign weights_ready  = weights_ready_q;
    assign init_act_valid = init_act_valid_q;
    assign init_act_data  = init_act_data_q;
    assign res_valid      = res_valid_q;
    assign res_acc0       = acc0_q;
    assign res_acc1       = acc1_q;
    assign res_status     = status_q;
    assign busy           = busy_q;
    assign seq_state_dbg  = state_q;

endmodule

// File: tb/tb_mlp_sequencer.sv
// Directed and randomized jobs against a cycle-level model of the sequencer timing.
module tb_mlp_sequencer;

    localparam int unsigned WBYTES         = 2;
    localparam int unsigned ACT_WORDS      = 2;
    localparam int unsigned ADDR_W         = 8;
    localparam int unsigned TIMEOUT_CYCLES = 16;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    job_valid = 1'b0;
    logic                    job_ready;
    logic [ADDR_W-1:0]       job_wbase = '0;
    logic [16*ACT_WORDS-1:0] job_act = '0;
    logic [2:0]              job_num_layers = '0;
    logic                    wmem_rd_en;
    logic [ADDR_W-1:0]       wmem_addr;
    logic [7:0]              wmem_rd_data = '0;
    logic                    wf_reset, wf_push_col0, wf_push_col1;
    logic [7:0]              wf_data_in;
    logic                    init_act_valid;
    logic [15:0]             init_act_data;
    logic                    start_mlp, weights_ready;
    logic                    mlp_layer_complete = 1'b0;
    logic                    mlp_acc_valid = 1'b0;
    logic signed [31:0]      mlp_acc0 = '0;
    logic signed [31:0]      mlp_acc1 = '0;
    logic                    res_valid;
    logic                    res_ready = 1'b0;
    logic signed [31:0]      res_acc0, res_acc1;
    logic [1:0]              res_status;
    logic                    busy;
    logic [2:0]              seq_state_dbg;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mem [256];

    always #5 clk = ~clk;

    // Weight memory stub: one-cycle read latency.
    always @(posedge clk) begin
        if (wmem_rd_en) wmem_rd_data <= mem[wmem_addr];
    end

    mlp_sequencer #(
        .WBYTES         (WBYTES),
        .ACT_WORDS      (ACT_WORDS),
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .job_valid          (job_valid),
        .job_ready          (job_ready),
        .job_wbase          (job_wbase),
        .job_act            (job_act),
        .job_num_layers     (job_num_layers),
        .wmem_rd_en         (wmem_rd_en),
        .wmem_addr          (wmem_addr),
        .wmem_rd_data       (wmem_rd_data),
        .wf_reset           (wf_reset),
        .wf_push_col0       (wf_push_col0),
        .wf_push_col1       (wf_push_col1),
        .wf_data_in         (wf_data_in),
        .init_act_valid     (init_act_valid),
        .init_act_data      (init_act_data),
        .start_mlp          (start_mlp),
        .weights_ready      (weights_ready),
        .mlp_layer_complete (mlp_layer_complete),
        .mlp_acc_valid      (mlp_acc_valid),
        .mlp_acc0           (mlp_acc0),
        .mlp_acc1           (mlp_acc1),
        .res_valid          (res_valid),
        .res_ready          (res_ready),
        .res_acc0           (res_acc0),
        .res_acc1           (res_acc1),
        .res_status         (res_status),
        .busy               (busy),
        .seq_state_dbg      (seq_state_dbg)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_job_ready", {63'd0, job_ready}, 64'd1);
        chk("rst_ctl", {busy, wf_reset, wf_push_col0, wf_push_col1, wmem_rd_en, init_act_valid,
                        start_mlp, weights_ready, res_valid, res_status, seq_state_dbg}, 64'd0);
        chk("rst_data", {wmem_addr, wf_data_in, init_act_data}, 64'd0);
        chk("rst_acc", {res_acc0, res_acc1}, 64'd0);
    endtask

    // One complete job: accept, weight stream, activations, arm, run, response.
    // Layer pulses land on RUN cycles gap, 2*gap, ... (np of them, 1-based).
    task automatic do_job(input logic [7:0] base, input logic [16*ACT_WORDS-1:0] act,
                          input logic [2:0] nl, input int gap, input int np, input bit acc_en,
                          input logic [31:0] a0, input logic [31:0] a1, input int rdy);
        int         t_bytes, pos, cnt, given, j;
        bit         fin, p;
        logic [7:0] ea;
        logic [1:0] st;
        logic [31:0] c0, c1;
        logic       exp_wr;

        c0 = '0;
        c1 = '0;
        exp_wr = (nl != 3'd0);
        job_valid = 1'b1;
        job_wbase = base;
        job_act = act;
        job_num_layers = nl;
        chk("job_ready", {63'd0, job_ready}, 64'd1);
        step();
        // Scramble the job inputs to show the fields were latched.
        job_valid = 1'b0;
        job_wbase = 8'($urandom);
        job_act = 32'($urandom);
        job_num_layers = 3'($urandom);

        if (nl == 3'd0) begin
            st = 2'd2;
            chk("bad_no_mlp", {wf_reset, wf_push_col0, wf_push_col1, wmem_rd_en, start_mlp,
                               weights_ready, init_act_valid}, 64'd0);
        end else begin
            t_bytes = int'(nl) * 2 * WBYTES;
            chk("wf_reset", {wf_reset, wmem_rd_en, busy}, 64'b101);
            step();
            for (int i = 0; i <= t_bytes; i++) begin
                chk("rd_en", {63'd0, wmem_rd_en}, {63'd0, i < t_bytes});
                ea = base + 8'(i);
                if (i < t_bytes) chk("rd_addr", {56'd0, wmem_addr}, {56'd0, ea});
                if (i == 0) begin
                    chk("no_push", {wf_push_col0, wf_push_col1, wf_reset}, 64'd0);
                end else begin
                    pos = (i - 1) % (2 * WBYTES);
                    chk("push_col", {wf_push_col0, wf_push_col1},
                        (pos < int'(WBYTES)) ? 64'b10 : 64'b01);
                    ea = base + 8'(i - 1);
                    chk("push_data", {56'd0, wf_data_in}, {56'd0, mem[ea]});
                end
                step();
            end
            for (int k = 0; k < ACT_WORDS; k++) begin
                // Junk MLP status outside RUN must be ignored.
                mlp_layer_complete = 1'b1;
                mlp_acc_valid = 1'b1;
                mlp_acc0 = $urandom;
                mlp_acc1 = $urandom;
                chk("act_valid", {init_act_valid, wf_push_col0, wf_push_col1, wmem_rd_en},
                    64'b1000);
                chk("act_data", {48'd0, init_act_data}, {48'd0, act[16*k +: 16]});
                step();
            end
            chk("arm", {start_mlp, weights_ready, init_act_valid}, 64'b110);
            step();
            cnt = 0;
            given = 0;
            j = 0;
            fin = 1'b0;
            st = 2'd1;
            while (!fin) begin
                j++;
                p = ((j % gap) == 0) && (given < np);
                mlp_layer_complete = p;
                mlp_acc_valid = 1'b0;
                if (p) begin
                    given++;
                    if (acc_en) begin
                        mlp_acc_valid = 1'b1;
                        mlp_acc0 = (given == np) ? a0 : $urandom;
                        mlp_acc1 = (given == np) ? a1 : $urandom;
                    end
                end else if (acc_en && $urandom_range(0, 3) == 0) begin
                    mlp_acc_valid = 1'b1;
                    mlp_acc0 = $urandom;
                    mlp_acc1 = $urandom;
                end
                if (mlp_acc_valid) begin
                    c0 = mlp_acc0;
                    c1 = mlp_acc1;
                end
                if (p) cnt++;
                chk("run", {busy, res_valid, start_mlp, weights_ready}, 64'b1001);
                step();
                if (cnt == int'(nl)) begin
                    st = 2'd0;
                    fin = 1'b1;
                end else if (j == int'(TIMEOUT_CYCLES)) begin
                    fin = 1'b1;
                end
            end
        end

        // Result phase; junk MLP status must not disturb the held result.
        mlp_layer_complete = 1'b1;
        mlp_acc_valid = 1'b1;
        mlp_acc0 = $urandom;
        mlp_acc1 = $urandom;
        res_ready = 1'b0;
        chk("res_ctl", {res_valid, res_status, job_ready, weights_ready, busy},
            {58'd0, 1'b1, st, 1'b0, exp_wr, 1'b1});
        chk("res_acc", {res_acc0, res_acc1}, {c0, c1});
        for (int d = 0; d < rdy; d++) begin
            step();
            chk("hold_ctl", {res_valid, res_status, job_ready, weights_ready},
                {59'd0, 1'b1, st, 1'b0, exp_wr});
            chk("hold_acc", {res_acc0, res_acc1}, {c0, c1});
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        mlp_layer_complete = 1'b0;
        mlp_acc_valid = 1'b0;
        chk("post_hs", {res_valid, job_ready, weights_ready, busy}, 64'b0100);
    endtask

    initial begin
        logic [2:0] nl;
        int         np;

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h10] = 8'hA1;
        mem[8'h11] = 8'hA2;
        mem[8'h12] = 8'hB1;
        mem[8'h13] = 8'hB2;

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk_reset_state();

        // Basic job.
        do_job(8'h10, 32'h0003_0005, 3'd1, 1, 1, 1'b1, 32'h0000_002A, 32'hFFFF_FFF9, 0);
        // Address wrap: FE, FF, 00, 01.
        do_job(8'hFE, 32'($urandom), 3'd1, 1, 1, 1'b1, 32'($urandom), 32'($urandom), 1);
        // Zero layers.
        do_job(8'($urandom), 32'($urandom), 3'd0, 1, 0, 1'b1, 32'd0, 32'd0, 2);
        // Timeout: only one of two layers completes.
        do_job(8'h20, 32'($urandom), 3'd2, 8, 1, 1'b1, 32'h1111_1111, 32'h2222_2222, 0);
        // Second layer lands on the final timeout cycle.
        do_job(8'h30, 32'($urandom), 3'd2, 8, 2, 1'b1, 32'h3333_3333, 32'hCCCC_CCCC, 0);
        // No accumulator capture, with result backpressure.
        do_job(8'h40, 32'($urandom), 3'd3, 2, 3, 1'b0, 32'd0, 32'd0, 10);

        // Reset in the middle of the weight stream.
        job_valid = 1'b1;
        job_wbase = 8'h50;
        job_num_layers = 3'd3;
        step();
        job_valid = 1'b0;
        step();
        step();
        step();
        chk("midrst_rd_en", {63'd0, wmem_rd_en}, 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_state();
        do_job(8'h50, 32'($urandom), 3'd3, 3, 3, 1'b1, 32'($urandom), 32'($urandom), 1);

        // Randomized jobs.
        for (int n = 0; n < 10; n++) begin
            nl = 3'($urandom_range(0, 7));
            np = $urandom_range(0, int'(nl));
            do_job(8'($urandom), 32'($urandom), nl, $urandom_range(1, 5), np,
                   1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom),
                   $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
